// File: rtl/btn_debounce_pulse_pkg.sv
// Shared board constants and the per-channel debounce FSM state type for the EGO1 push-button front end.
package btn_debounce_pulse_pkg;

  localparam int unsigned EGO1_CLK_HZ         = 100000000;
  localparam int unsigned DEBOUNCE_MS_DEFAULT = 20;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_PRESS = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_WAIT_REL   = 2'd3
  } db_state_e;

  function automatic int unsigned db_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/btn_debounce_pulse_debounce_channel.sv
// One button channel: 2-FF synchronizer, then a 4-state debounce FSM with a stability counter.
// All outputs are registered; the level output never decodes the state bits combinationally.
module debounce_channel
  import btn_debounce_pulse_pkg::*;
#(
  parameter int unsigned CLK_HZ      = EGO1_CLK_HZ,
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic i_cp,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned CW        = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

  if (DB_CYCLES < 2) begin : g_db_check
    $error("debounce_channel: DB_CYCLES must be >= 2");
  end

  logic          r_s1;
  logic          r_s;
  db_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;
  logic          r_release;

  db_state_e     w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_level_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_cnt_done;

  // Compare at 32 bits so the terminal count is never truncated to the counter width.
  assign w_cnt_done = (32'(r_cnt) == (DB_CYCLES - 1));

  always_ff @(posedge i_cp or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1      <= 1'b0;
      r_s       <= 1'b0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_s1      <= i_btn_raw;
      r_s       <= r_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_level_nxt = 1'b0;
        if (r_s) begin
          w_state_nxt = ST_WAIT_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_PRESS: begin
        if (!r_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_PRESSED;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        w_level_nxt = 1'b1;
        if (!r_s) begin
          w_state_nxt = ST_WAIT_REL;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_REL: begin
        if (r_s) begin
          w_state_nxt = ST_PRESSED;
        end else if (w_cnt_done) begin
          w_state_nxt   = ST_IDLE;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/btn_debounce_pulse.sv
// EGO1 button conditioning: N independent debounce channels producing clean levels and press/release pulses on cp.
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int unsigned N_BTN       = 5,
  parameter int unsigned CLK_HZ      = EGO1_CLK_HZ,
  parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  genvar gi;
  for (gi = 0; gi < N_BTN; gi++) begin : g_ch
    debounce_channel #(
      .CLK_HZ      (CLK_HZ),
      .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_ch (
      .i_cp      (cp),
      .i_rst_n   (rst_n),
      .i_btn_raw (btn_raw[gi]),
      .o_level   (btn_level[gi]),
      .o_press   (btn_press[gi]),
      .o_release (btn_release[gi])
    );
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Scoreboard bench for btn_debounce_pulse with DB_CYCLES=4: expected pulses are queued with their cycle number.
module tb_btn_debounce_pulse;

  logic       cp;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_press;
  logic [4:0] btn_release;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  press;
    logic [4:0]  rel;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          failures;
  bit          mon_en;
  logic [4:0]  mon_p;
  logic [4:0]  mon_r;
  logic [1:0]  cnt2 [5];

  btn_debounce_pulse #(
    .N_BTN       (5),
    .CLK_HZ      (1000),
    .DEBOUNCE_MS (4)
  ) dut (
    .cp          (cp),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  always @(posedge cp) cyc <= cyc + 1;

  // Downstream 2-bit counters, one per channel, clock-enabled by the press pulse.
  always @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) cnt2[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 5; i++) if (btn_press[i]) cnt2[i] <= cnt2[i] + 2'd1;
    end
  end

  always @(negedge cp) begin
    if (mon_en) begin
      mon_p = 5'b00000;
      mon_r = 5'b00000;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_p = sb[0].press;
        mon_r = sb[0].rel;
        void'(sb.pop_front());
      end
      checks++;
      if (btn_press !== mon_p) begin
        failures++;
        $display("FAIL pulse_press cyc=%0d got=%b want=%b", cyc, btn_press, mon_p);
      end
      checks++;
      if (btn_release !== mon_r) begin
        failures++;
        $display("FAIL pulse_release cyc=%0d got=%b want=%b", cyc, btn_release, mon_r);
      end
    end
  end

  task automatic test_reset();
    rst_n   = 1'b1;
    btn_raw = 5'b00000;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge cp);
    checks++;
    if ({btn_level, btn_press, btn_release} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {btn_level, btn_press, btn_release});
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge cp);
  endtask

  task automatic test_clean_press();
    int unsigned k;
    logic [4:0]  exp;
    @(negedge cp);
    btn_raw[0] = 1'b1;
    k = cyc;
    sb.push_back('{k + 7, 5'b00001, 5'b00000});
    for (int i = 0; i < 10; i++) begin
      @(negedge cp);
      exp = (cyc >= k + 7) ? 5'b00001 : 5'b00000;
      checks++;
      if (btn_level !== exp) begin
        failures++;
        $display("FAIL clean_press_level cyc=%0d got=%b want=%b", cyc, btn_level, exp);
      end
    end
  endtask

  task automatic test_bounce();
    int unsigned k;
    logic        exp;
    @(negedge cp) btn_raw[1] = 1'b1;
    @(negedge cp) btn_raw[1] = 1'b0;
    @(negedge cp) btn_raw[1] = 1'b1;
    @(negedge cp) btn_raw[1] = 1'b0;
    @(negedge cp) btn_raw[1] = 1'b1;
    k = cyc;
    sb.push_back('{k + 7, 5'b00010, 5'b00000});
    for (int i = 0; i < 10; i++) begin
      @(negedge cp);
      exp = (cyc >= k + 7);
      checks++;
      if (btn_level[1] !== exp) begin
        failures++;
        $display("FAIL bounce_level cyc=%0d got=%b want=%b", cyc, btn_level[1], exp);
      end
    end
  endtask

  task automatic test_release();
    int unsigned k;
    logic        exp;
    @(negedge cp);
    btn_raw[0] = 1'b0;
    k = cyc;
    sb.push_back('{k + 7, 5'b00000, 5'b00001});
    for (int i = 0; i < 10; i++) begin
      @(negedge cp);
      exp = (cyc < k + 7);
      checks++;
      if (btn_level[0] !== exp) begin
        failures++;
        $display("FAIL release_level cyc=%0d got=%b want=%b", cyc, btn_level[0], exp);
      end
    end
  endtask

  task automatic test_short_drop();
    int unsigned k;
    @(negedge cp);
    btn_raw[2] = 1'b1;
    sb.push_back('{cyc + 7, 5'b00100, 5'b00000});
    repeat (10) @(negedge cp);
    btn_raw[2] = 1'b0;
    repeat (3) @(negedge cp);
    btn_raw[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge cp);
      checks++;
      if (btn_level[2] !== 1'b1) begin
        failures++;
        $display("FAIL short_drop_level cyc=%0d got=%b want=1", cyc, btn_level[2]);
      end
    end
    btn_raw[2:1] = 2'b00;
    k = cyc;
    sb.push_back('{k + 7, 5'b00000, 5'b00110});
    repeat (10) @(negedge cp);
    checks++;
    if (btn_level !== 5'b00000) begin
      failures++;
      $display("FAIL short_drop_released got=%b want=00000", btn_level);
    end
  endtask

  task automatic test_reset_mid_wait();
    int unsigned r;
    logic        exp;
    @(negedge cp);
    btn_raw[4] = 1'b1;
    sb.push_back('{cyc + 7, 5'b10000, 5'b00000});
    repeat (10) @(negedge cp);
    btn_raw[3] = 1'b1;
    repeat (5) @(negedge cp);
    checks++;
    if (btn_level !== 5'b10000) begin
      failures++;
      $display("FAIL pre_reset_level got=%b want=10000", btn_level);
    end
    #2;
    rst_n      = 1'b0;
    btn_raw[4] = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release} !== 15'd0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%b want=0", {btn_level, btn_press, btn_release});
    end
    @(negedge cp);
    @(negedge cp);
    rst_n = 1'b1;
    r = cyc;
    sb.push_back('{r + 7, 5'b01000, 5'b00000});
    for (int i = 0; i < 10; i++) begin
      @(negedge cp);
      exp = (cyc >= r + 7);
      checks++;
      if (btn_level[3] !== exp) begin
        failures++;
        $display("FAIL post_reset_level cyc=%0d got=%b want=%b", cyc, btn_level[3], exp);
      end
    end
    btn_raw[3] = 1'b0;
    sb.push_back('{cyc + 7, 5'b00000, 5'b01000});
    repeat (10) @(negedge cp);
  endtask

  task automatic test_simultaneous();
    int unsigned k;
    logic [4:0]  exp;
    logic [1:0]  snap [5];
    logic [1:0]  want;
    for (int i = 0; i < 5; i++) snap[i] = cnt2[i];
    @(negedge cp);
    btn_raw = 5'b10101;
    k = cyc;
    sb.push_back('{k + 7, 5'b10101, 5'b00000});
    for (int i = 0; i < 10; i++) begin
      @(negedge cp);
      exp = (cyc >= k + 7) ? 5'b10101 : 5'b00000;
      checks++;
      if (btn_level !== exp) begin
        failures++;
        $display("FAIL simul_level cyc=%0d got=%b want=%b", cyc, btn_level, exp);
      end
    end
    for (int i = 0; i < 5; i++) begin
      want = snap[i] + ((i % 2 == 0) ? 2'd1 : 2'd0);
      checks++;
      if (cnt2[i] !== want) begin
        failures++;
        $display("FAIL counter_advance ch=%0d got=%0d want=%0d", i, cnt2[i], want);
      end
    end
    btn_raw = 5'b00000;
    sb.push_back('{cyc + 7, 5'b00000, 5'b10101});
    repeat (10) @(negedge cp);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_short_drop();
    test_reset_mid_wait();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
